// File: rtl/ram_stream_writer.sv
// rtl/ram_stream_writer.sv - buffers a 16-bit stream and writes it into consecutive RAM blocks
module ram_stream_writer #(
  parameter int BlockWidth = 21,
  parameter int BlockSize  = 16,
  parameter int CountWidth = 21,
  parameter int FifoDepth  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_trigger,
  output logic                  start_ready,
  input  logic [BlockWidth-1:0] start_block,
  input  logic [CountWidth-1:0] start_blockCount,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_data,
  input  logic                  cmd_ready,
  output logic                  cmd_trigger,
  output logic [BlockWidth-1:0] cmd_block,
  output logic                  cmd_write,
  input  logic                  data_ready,
  output logic                  data_trigger,
  output logic [15:0]           data_write,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = $clog2(FifoDepth);
  localparam int OW = AW + 1;
  localparam int IW = (BlockSize > 1) ? $clog2(BlockSize) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  state_t                state;
  logic [CountWidth-1:0] blocks_left;
  logic [IW-1:0]         word_idx;

  logic [15:0]   mem [FifoDepth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] count;
  logic [OW-1:0] count_next;
  logic          empty;
  logic          push;
  logic          pop;
  logic          start_acc;
  logic          last_word;

  assign empty        = (count == '0);
  assign push         = in_valid && in_ready;
  assign data_trigger = (state == S_DATA) && !empty;
  assign pop          = data_trigger && data_ready;
  assign data_write   = mem[rd_ptr];
  assign count_next   = count + OW'(push) - OW'(pop);
  assign start_ready  = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign cmd_write    = 1'b1;
  assign start_acc    = start_trigger && start_ready;
  assign last_word    = (word_idx == IW'(BlockSize - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // in_ready looks only at the registered occupancy, so a full FIFO never takes a push
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      in_ready <= (count_next != OW'(FifoDepth));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_trigger <= 1'b0;
      cmd_block   <= '0;
      blocks_left <= '0;
      word_idx    <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            if (start_blockCount == '0) begin
              done <= 1'b1;
            end else begin
              cmd_block   <= start_block;
              blocks_left <= start_blockCount;
              cmd_trigger <= 1'b1;
              state       <= S_CMD;
            end
          end
        end
        S_CMD: begin
          if (cmd_ready && cmd_trigger) begin
            cmd_trigger <= 1'b0;
            word_idx    <= '0;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          if (pop) begin
            word_idx <= word_idx + IW'(1);
            if (last_word) begin
              blocks_left <= blocks_left - CountWidth'(1);
              if (blocks_left == CountWidth'(1)) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                cmd_block   <= cmd_block + BlockWidth'(1);
                cmd_trigger <= 1'b1;
                state       <= S_CMD;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
